// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - instruction handshake between upstream and the ALU op sequencer
interface alu_op_sequencer_if #(
    parameter int INSTR_W = 32
);
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_in;
    logic               instr_ready;

    modport master (output instr_valid, output instr_in, input instr_ready);
    modport slave  (input instr_valid, input instr_in, output instr_ready);
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - RV32I ALU-op decode and IDLE/DECODE/EXEC/WB sequencing for the regfile/ALU datapath
// Optional ALU_SEQ_BACK_TO_BACK_EN: accept the next instruction in WB and go straight to DECODE.
module alu_op_sequencer #(
    parameter int INSTR_W = 32,
    parameter int CTRL_W  = 6,
    parameter int CNT_W   = 16
) (
    input  logic                clock,
    input  logic                reset,
    alu_op_sequencer_if.slave   instr_if,
    input  logic                hold,
    output logic [INSTR_W-1:0]  instruction,
    output logic [CTRL_W-1:0]   ALU_Control,
    output logic                op_B_sel,
    output logic                wEn,
    output logic                illegal,
    output logic                busy,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic       accept;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] dec_ctrl;
    logic       dec_bsel;
    logic       dec_legal;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    always_comb begin
        dec_ctrl  = 6'b000000;
        dec_bsel  = 1'b0;
        dec_legal = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_ctrl  = {2'b00, funct7[5], funct3};
                dec_legal = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            7'b0010011: begin
                dec_bsel = 1'b1;
                // Only srai carries the funct7[5] modifier among immediate ops
                dec_ctrl = ((funct3 == 3'b101) && instruction[30]) ? 6'b001101 : {3'b000, funct3};
                case (funct3)
                    3'b001:  dec_legal = (funct7 == 7'b0000000);
                    3'b101:  dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: dec_legal = 1'b1;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        instr_if.instr_ready = 1'b0;
        if (reset) begin
`ifdef ALU_SEQ_BACK_TO_BACK_EN
            instr_if.instr_ready = (state == IDLE) || (state == WB);
`else
            instr_if.instr_ready = (state == IDLE);
`endif
        end
    end

    assign accept  = instr_if.instr_valid && instr_if.instr_ready;
    assign busy    = (state != IDLE);
    assign illegal = (state == DECODE) && !dec_legal;
    // Combinational from the state register so an async reset drops it immediately
    assign wEn     = (state == WB) && (instruction[11:7] != 5'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DECODE;
            DECODE:  state_nxt = dec_legal ? EXEC : IDLE;
            EXEC:    if (!hold) state_nxt = WB;
            WB: begin
`ifdef ALU_SEQ_BACK_TO_BACK_EN
                state_nxt = accept ? DECODE : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            instruction <= '0;
            ALU_Control <= '0;
            op_B_sel    <= 1'b0;
            retired     <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                instruction <= instr_if.instr_in;
            if ((state == DECODE) && dec_legal) begin
                ALU_Control <= CTRL_W'(dec_ctrl);
                op_B_sel    <= dec_bsel;
            end
            if (state == WB)
                retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        hold;
    logic [31:0] instruction;
    logic [5:0]  ALU_Control;
    logic        op_B_sel;
    logic        wEn;
    logic        illegal;
    logic        busy;
    logic [15:0] retired;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_retired = 16'd0;

    localparam logic [31:0] ADDI_A1  = 32'h00100593;
    localparam logic [31:0] SUB_A7   = 32'h40E608B3;
    localparam logic [31:0] ADDI_X0  = 32'h00500013;
    localparam logic [31:0] SRAI_X1  = 32'h4020D093;
    localparam logic [31:0] SLLI_BAD = 32'h40209093;
    localparam logic [31:0] ZERO_INS = 32'h00000000;

`ifdef ALU_SEQ_BACK_TO_BACK_EN
    localparam logic WB_READY = 1'b1;
`else
    localparam logic WB_READY = 1'b0;
`endif

    alu_op_sequencer_if #(.INSTR_W(32)) bus ();

    alu_op_sequencer #(.INSTR_W(32), .CTRL_W(6), .CNT_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_if    (bus),
        .hold        (hold),
        .instruction (instruction),
        .ALU_Control (ALU_Control),
        .op_B_sel    (op_B_sel),
        .wEn         (wEn),
        .illegal     (illegal),
        .busy        (busy),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_legal(input logic [31:0] ins, input logic [5:0] ctrl, input logic bsel);
        logic [4:0] rd;
        rd = ins[11:7];
        bus.instr_valid = 1'b1;
        bus.instr_in    = ins;
        step();
        bus.instr_valid = 1'b0;
        check("dec_busy", 32'(busy), 32'd1);
        check("dec_ready", 32'(bus.instr_ready), 32'd0);
        check("dec_illegal", 32'(illegal), 32'd0);
        check("dec_instr", instruction, ins);
        step();
        check("exec_ctrl", 32'(ALU_Control), 32'(ctrl));
        check("exec_bsel", 32'(op_B_sel), 32'(bsel));
        check("exec_wen", 32'(wEn), 32'd0);
        step();
        check("wb_wen", 32'(wEn), (rd != 5'd0) ? 32'd1 : 32'd0);
        check("wb_ready", 32'(bus.instr_ready), 32'(WB_READY));
        check("wb_retired", 32'(retired), 32'(exp_retired));
        exp_retired = exp_retired + 16'd1;
        step();
        check("idle_wen", 32'(wEn), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(bus.instr_ready), 32'd1);
        check("idle_retired", 32'(retired), 32'(exp_retired));
        check("idle_ctrl_hold", 32'(ALU_Control), 32'(ctrl));
    endtask

    task automatic run_illegal(input logic [31:0] ins, input logic [5:0] prev_ctrl);
        bus.instr_valid = 1'b1;
        bus.instr_in    = ins;
        step();
        bus.instr_valid = 1'b0;
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_dec_wen", 32'(wEn), 32'd0);
        step();
        check("ill_pulse_end", 32'(illegal), 32'd0);
        check("ill_ready", 32'(bus.instr_ready), 32'd1);
        check("ill_busy", 32'(busy), 32'd0);
        check("ill_wen", 32'(wEn), 32'd0);
        check("ill_retired", 32'(retired), 32'(exp_retired));
        check("ill_ctrl_hold", 32'(ALU_Control), 32'(prev_ctrl));
    endtask

    initial begin
        reset           = 1'b0;
        hold            = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_in    = 32'd0;
        #3;
        check("rst_ready", 32'(bus.instr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wen", 32'(wEn), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_ctrl", 32'(ALU_Control), 32'd0);
        check("rst_bsel", 32'(op_B_sel), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rel_ready", 32'(bus.instr_ready), 32'd1);

        run_legal(ADDI_A1, 6'b000000, 1'b1);
        run_legal(SUB_A7, 6'b001000, 1'b0);
        run_illegal(ZERO_INS, 6'b001000);
        run_legal(ADDI_X0, 6'b000000, 1'b1);
        run_legal(SRAI_X1, 6'b001101, 1'b1);
        run_illegal(SLLI_BAD, 6'b001101);

        // Stall in EXEC with a competing request that must not be taken
        bus.instr_valid = 1'b1;
        bus.instr_in    = ADDI_A1;
        step();
        bus.instr_valid = 1'b0;
        hold = 1'b1;
        step();
        bus.instr_valid = 1'b1;
        bus.instr_in    = SUB_A7;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_wen", 32'(wEn), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_ready", 32'(bus.instr_ready), 32'd0);
            check("stall_instr", instruction, ADDI_A1);
            check("stall_ctrl", 32'(ALU_Control), 32'd0);
            check("stall_bsel", 32'(op_B_sel), 32'd1);
        end
        hold = 1'b0;
        bus.instr_valid = 1'b0;
        step();
        check("stall_wb_wen", 32'(wEn), 32'd1);
        exp_retired = exp_retired + 16'd1;
        step();
        check("stall_after_wen", 32'(wEn), 32'd0);
        check("stall_after_retired", 32'(retired), 32'(exp_retired));
        check("stall_after_instr", instruction, ADDI_A1);

        // Reset in the middle of EXEC aborts without a write
        bus.instr_valid = 1'b1;
        bus.instr_in    = SUB_A7;
        step();
        bus.instr_valid = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        check("abort_wen", 32'(wEn), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_retired", 32'(retired), 32'd0);
        check("abort_instr", instruction, 32'd0);
        exp_retired = 16'd0;
        @(negedge clock);
        reset = 1'b1;
        run_legal(ADDI_A1, 6'b000000, 1'b1);

`ifdef ALU_SEQ_BACK_TO_BACK_EN
        bus.instr_valid = 1'b1;
        bus.instr_in    = ADDI_A1;
        step();
        bus.instr_in    = SUB_A7;
        step();
        step();
        check("b2b_wen_a", 32'(wEn), 32'd1);
        check("b2b_ready_wb", 32'(bus.instr_ready), 32'd1);
        step();
        bus.instr_valid = 1'b0;
        check("b2b_decode_b", instruction, SUB_A7);
        check("b2b_wen_gap", 32'(wEn), 32'd0);
        step();
        check("b2b_ctrl_b", 32'(ALU_Control), 32'b001000);
        step();
        check("b2b_wen_b", 32'(wEn), 32'd1);
        exp_retired = exp_retired + 16'd2;
        step();
        check("b2b_retired", 32'(retired), 32'(exp_retired));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
